// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit, generalised to XLEN.
// One bit per cycle: shift-add multiply and restoring divide on operand
// magnitudes, followed by a sign-fix cycle. Divide-by-zero and signed
// overflow are resolved at accept and answer on the next cycle.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int CNT_BITS = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0]     ZERO_X  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]     ONES_X  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]     ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]     MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0]   ONE_P   = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's complement negation over XLEN bits
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return (~v) + ONE_X;
    endfunction

    // Two's complement negation over the full 2*XLEN product
    function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v);
        return (~v) + ONE_P;
    endfunction

    state_t               state_r, state_next_s;
    logic [CNT_BITS-1:0]  cnt_r;
    logic [2:0]           op_r;
    logic                 sign1_r, sign2_r;
    logic [2*XLEN-1:0]    acc_r;      // product, or {remainder, quotient}
    logic [XLEN-1:0]      opnd_r;     // multiplicand or divisor magnitude
    logic                 in_ready_r, busy_r, out_valid_r;
    logic [XLEN-1:0]      result_r;

    logic                 accept_s;
    logic                 sign1_s, sign2_s, special_s;
    logic [XLEN-1:0]      mag1_s, mag2_s, special_val_s;
    logic [XLEN:0]        mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0]    mul_next_s, div_next_s, prod_fix_s;
    logic [XLEN-1:0]      quo_fix_s, rem_fix_s, fix_val_s;

    assign accept_s  = in_valid & (state_r == ST_IDLE) & ~flush;
    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

    // Operand decode at accept: signs, magnitudes and special-case divides
    always_comb begin
        sign1_s       = 1'b0;
        sign2_s       = 1'b0;
        special_s     = 1'b0;
        special_val_s = ZERO_X;
        if ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM)) begin
            sign1_s = src1[XLEN-1];
        end else begin
            sign1_s = 1'b0;
        end
        if ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) begin
            sign2_s = src2[XLEN-1];
        end else begin
            sign2_s = 1'b0;
        end
        if (op[2] && (src2 == ZERO_X)) begin
            special_s     = 1'b1;
            special_val_s = op[1] ? src1 : ONES_X;
        end else if (op[2] && !op[0] && (src1 == MIN_X) && (src2 == ONES_X)) begin
            special_s     = 1'b1;
            special_val_s = op[1] ? ZERO_X : src1;
        end else begin
            special_s     = 1'b0;
            special_val_s = ZERO_X;
        end
        mag1_s = sign1_s ? neg_x(src1) : src1;
        mag2_s = sign2_s ? neg_x(src2) : src2;
    end

    // One iteration step for both shift-add multiply and restoring divide
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_X});
        mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
        div_shift_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        // remainder < divisor keeps shifted value below 2*divisor, so the
        // difference's top bit alone tells whether the subtraction fits
        if (!div_diff_s[XLEN]) begin
            div_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and result selection used in the FIX state
    always_comb begin
        prod_fix_s = (sign1_r ^ sign2_r) ? neg_p(acc_r) : acc_r;
        quo_fix_s  = (sign1_r ^ sign2_r) ? neg_x(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
        rem_fix_s  = sign1_r ? neg_x(acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
        case (op_r)
            OP_MUL:                      fix_val_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_val_s = quo_fix_s;
            OP_REM, OP_REMU:             fix_val_s = rem_fix_s;
            default:                     fix_val_s = ZERO_X;
        endcase
    end

    // Next-state logic; flush returns any busy state to IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = special_s ? ST_DONE : ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_ONE) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: capture operands at accept, iterate in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_BITS{1'b0}};
            op_r    <= 3'b000;
            sign1_r <= 1'b0;
            sign2_r <= 1'b0;
            acc_r   <= {(2*XLEN){1'b0}};
            opnd_r  <= ZERO_X;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r   <= CNT_MAX;
                        op_r    <= op;
                        sign1_r <= sign1_s;
                        sign2_r <= sign2_s;
                        acc_r   <= {ZERO_X, op[2] ? mag1_s : mag2_s};
                        opnd_r  <= op[2] ? mag2_s : mag1_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    acc_r <= op_r[2] ? div_next_s : mul_next_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered handshake/status outputs and the result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= ZERO_X;
        end else begin
            in_ready_r  <= (state_next_s == ST_IDLE);
            busy_r      <= (state_next_s != ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            if (state_next_s == ST_DONE) begin
                result_r <= (state_r == ST_IDLE) ? special_val_s : fix_val_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases at XLEN=32 plus
// back-to-back random operations at XLEN=8 and XLEN=32 against a
// 64-bit integer reference model. Expected results and output cycles
// go into per-instance queues and are popped when out_valid pulses.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          acc_edge = 0;

    logic        in_valid32 = 1'b0, flush32 = 1'b0;
    logic [2:0]  op32 = 3'd0;
    logic [31:0] a32 = 32'd0, b32 = 32'd0;
    logic        in_ready32, busy32, out_valid32;
    logic [31:0] result32;

    logic        in_valid8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        in_ready8, busy8, out_valid8;
    logic [7:0]  result8;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op32), .src1(a32), .src2(b32), .flush(flush32), .busy(busy32),
        .out_valid(out_valid32), .result(result32)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .src1(a8), .src2(b8), .flush(flush8), .busy(busy8),
        .out_valid(out_valid8), .result(result8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input int w);
        longint mask, ua, ub, sa, sb, r, minv;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = a[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = b[w-1] ? ub - (longint'(1) << w) : ub;
        minv = -(longint'(1) << (w - 1));
        case (o)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: r = (ua * ub) >>> w;
            3'd4: r = (ub == 0) ? -1 : ((sa == minv && sb == -1) ? sa : sa / sb);
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: r = (ub == 0) ? sa : ((sa == minv && sb == -1) ? 0 : sa % sb);
            3'd7: r = (ub == 0) ? ua : ua % ub;
            default: r = 0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b, input int w);
        longint mask, ua, ub;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        return o[2] && ((ub == 0) ||
               (!o[0] && ua == (longint'(1) << (w - 1)) && ub == mask));
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input bit w8, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input int lat,
                         input bit expect_out, input bit hold);
        int   n;
        logic rdy;
        exp_t e;
        if (w8) begin
            op8 = o; a8 = a[7:0]; b8 = b[7:0]; in_valid8 = 1'b1;
        end else begin
            op32 = o; a32 = a; b32 = b; in_valid32 = 1'b1;
        end
        n = 0;
        rdy = w8 ? in_ready8 : in_ready32;
        while (!rdy && n < 300) begin
            @(negedge clk);
            n++;
            rdy = w8 ? in_ready8 : in_ready32;
        end
        chk("accept_ready", {31'd0, rdy}, 32'd1);
        if (rdy) begin
            acc_edge = cyc + 1;
            e.val = expv;
            e.cyc = cyc + 1 + lat;
            if (expect_out) begin
                if (w8) q8.push_back(e);
                else    q32.push_back(e);
            end
            @(negedge clk);
        end
        if (!hold) begin
            if (w8) in_valid8 = 1'b0;
            else    in_valid32 = 1'b0;
        end
    endtask

    // Scoreboard for the 32-bit instance
    always @(negedge clk) begin
        if (rst_n && out_valid32) begin
            if (q32.size() == 0) begin
                chk("unexpected_out32", {31'd0, out_valid32}, 32'd0);
            end else begin
                e32 = q32.pop_front();
                chk("result32", result32, e32.val);
                chk("latency32", 32'(cyc), 32'(e32.cyc));
            end
        end else if (q32.size() != 0 && q32[0].cyc <= cyc) begin
            e32 = q32.pop_front();
            chk("missing_out32", {31'd0, out_valid32}, 32'd1);
        end
    end

    // Scoreboard for the 8-bit instance
    always @(negedge clk) begin
        if (rst_n && out_valid8) begin
            if (q8.size() == 0) begin
                chk("unexpected_out8", {31'd0, out_valid8}, 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("result8", {24'd0, result8}, e8.val);
                chk("latency8", 32'(cyc), 32'(e8.cyc));
            end
        end else if (q8.size() != 0 && q8[0].cyc <= cyc) begin
            e8 = q8.pop_front();
            chk("missing_out8", {31'd0, out_valid8}, 32'd1);
        end
    end

    initial begin
        int          n, prev_acc, w;
        bit          w8, sp, prev_sp;
        logic [2:0]  o;
        logic [31:0] a, b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready32", {31'd0, in_ready32}, 32'd1);
        chk("rst_busy32", {31'd0, busy32}, 32'd0);
        chk("rst_valid32", {31'd0, out_valid32}, 32'd0);
        chk("rst_result32", result32, 32'd0);
        chk("rst_status8", {29'd0, in_ready8, busy8, out_valid8}, 32'd4);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7 x -3 with exact latency and busy window
        issue(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1, 1'b0);
        for (int i = 0; i < 34; i++) begin
            chk("busy_window", {30'd0, in_ready32, busy32}, 32'd1);
            @(negedge clk);
        end
        chk("idle_after_mul", {30'd0, in_ready32, busy32}, 32'd2);

        // High multiplies
        issue(1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b1, 1'b0);
        issue(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1, 1'b0);
        issue(1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1, 1'b0);

        // Divides
        issue(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1, 1'b0);
        issue(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1, 1'b0);
        issue(1'b0, 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b1, 1'b0);
        issue(1'b0, 3'd7, 32'd100, 32'd7, 32'd2, 33, 1'b1, 1'b0);

        // Special cases answer one cycle after accept
        issue(1'b0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);
        issue(1'b0, 3'd7, 32'd5, 32'd0, 32'd5, 0, 1'b1, 1'b0);
        issue(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b1, 1'b0);
        issue(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b1, 1'b0);

        // Flush mid-divide, then a fresh MUL
        issue(1'b0, 3'd5, 32'd1000, 32'd3, 32'd333, 33, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        chk("flush_idle", {30'd0, in_ready32, busy32}, 32'd2);
        issue(1'b0, 3'd0, 32'd3, 32'd4, 32'd12, 33, 1'b1, 1'b0);
        repeat (40) @(negedge clk);

        // Reset mid-divide
        issue(1'b0, 3'd5, 32'd1000, 32'd3, 32'd333, 33, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_status", {29'd0, in_ready32, busy32, out_valid32}, 32'd4);
        chk("midrst_result", result32, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back random ops, in_valid held high, both widths
        for (int wi = 0; wi < 2; wi++) begin
            w8 = (wi == 0);
            w = w8 ? 8 : 32;
            prev_sp = 1'b0;
            prev_acc = 0;
            for (int k = 0; k < 32; k++) begin
                o = 3'(k % 8);
                a = $urandom;
                b = $urandom;
                if (w8) begin
                    a = a & 32'h0000_00FF;
                    b = b & 32'h0000_00FF;
                end
                if (b == 32'd0) b = 32'd1;
                sp = is_special(o, a, b, w);
                issue(w8, o, a, b, ref_model(o, a, b, w), sp ? 0 : w + 1, 1'b1, k != 31);
                if (k != 0) begin
                    chk(w8 ? "spacing8" : "spacing32", 32'(acc_edge - prev_acc),
                        prev_sp ? 32'd2 : 32'(w + 3));
                end
                prev_acc = acc_edge;
                prev_sp = sp;
            end
        end

        // Drain outstanding results
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q32.size() + q8.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit for the RV32M extension (generalised to XLEN), sitting beside the single-cycle ALU in the EX stage.
- Accepts one operation through a valid/ready handshake and computes it bit-serially, one bit per cycle.
- Returns the result with a one-cycle valid pulse; the pipeline stalls on `busy`.
- Supports flush, so a squashed instruction never writes back.

Parameters:
- XLEN, 32, operand/result width; legal values are any even integer >= 4.
- CNT_BITS, $clog2(XLEN+1), width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept an operation this cycle
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  in  XLEN  rs1 operand (multiplicand / dividend)
- src2  in  XLEN  rs2 operand (multiplier / divisor)
- flush  in  1  abort the in-flight operation
- busy  out  1  operation in flight (state != IDLE)
- out_valid  out  1  one-cycle result pulse
- result  out  XLEN  result, valid only while out_valid = 1

Behaviour:
- Clock and reset
  - One clock.
  - Reset is asynchronous, active-low.
  - While rst_n = 0: state = IDLE, in_ready = 1, busy = 0, out_valid = 0, result = 0, and all datapath registers are cleared.
- Accept
  - An operation is accepted on a rising edge where in_valid & in_ready & ~flush.
  - op, src1 and src2 are captured at that edge; later changes on the inputs have no effect.
  - in_ready = (state == IDLE).
- States
  - IDLE -> CALC on accept, or IDLE -> DONE on accept of a special-case divide.
  - CALC -> FIX after XLEN iterations, tracked by a counter that runs from XLEN down to 1.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
- Latency
  - If accept is at edge T, out_valid = 1 during cycle T+XLEN+2 (i.e. T+34 for XLEN = 32).
  - Special cases assert out_valid at T+1.
  - out_valid is high only in DONE. There is no output backpressure.
- Signedness
  - src1 is signed for MULH, MULHSU, DIV and REM.
  - src2 is signed for MULH, DIV and REM.
  - Signed operands are converted to magnitude at accept, and their sign bits are stored.
- Multiply
  - Unsigned shift-add on magnitudes into a 2*XLEN product register.
  - FIX negates the product (two's complement over 2*XLEN bits) if sign1 ^ sign2.
  - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Divide
  - Restoring division on magnitudes, one quotient bit per cycle.
  - FIX negates the quotient if sign1 ^ sign2, and negates the remainder if sign1 (the remainder takes the sign of the dividend).
- Special cases (detected at accept, no iteration)
  - Divisor = 0: DIV/DIVU return all ones; REM/REMU return src1.
  - Signed overflow (src1 = 100..0, src2 = all ones, DIV/REM only): DIV returns src1; REM returns 0.
  - MUL ops with zero operands are not special-cased; they take full latency.
- Flush
  - flush = 1 in any non-IDLE state forces the next state to IDLE. out_valid stays 0 on that edge and on all later edges for the aborted op.
  - flush takes priority over accept in the same cycle: no accept occurs.
  - flush during DONE suppresses nothing already asserted; the pulse in the current cycle stands.
- Reset mid-operation aborts immediately; no out_valid is produced.
- Back-to-back operation: a new op may be accepted in the cycle after DONE, with in_valid held high throughout.
- result holds its last value outside DONE.

Test Plan:
1. XLEN=32, accept MUL src1=7, src2=0xFFFFFFFD at T -> out_valid only at T+34, result=0xFFFFFFEB; in_ready=0 and busy=1 from T+1 to T+34.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
4. DIV 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; REM same operands -> 0.
5. Accept DIVU at T, flush=1 at T+10 -> in_ready=1 at T+11 and no out_valid through T+40; MUL 3x4 accepted at T+11 -> 12 at T+45. Repeat with rst_n pulled low at T+10 -> all outputs at reset values immediately.
6. in_valid held high with 4 random ops of each opcode (XLEN=8 and XLEN=32) -> each result matches a reference model, and consecutive accepts are exactly XLEN+3 cycles apart.
